// File: rtl/clint_timer_pkg.sv
// clint_timer_pkg: register offsets, state structs and byte-merge helper for the CLINT timer.
package clint_timer_pkg;
  localparam logic [15:0] clint_msip      = 16'h0000;
  localparam logic [15:0] clint_mtimecmp  = 16'h4000;
  localparam logic [15:0] clint_mtimecmph = 16'h4004;
  localparam logic [15:0] clint_mtime     = 16'hBFF8;
  localparam logic [15:0] clint_mtimeh    = 16'hBFFC;

  typedef struct packed {
    logic        msip;
    logic [63:0] mtimecmp;
    logic [63:0] mtime;
    logic        ready;
    logic [31:0] rdata;
    logic        mtip;
  } clint_reg_type;

  localparam clint_reg_type init_clint_reg = '{
    msip: 1'b0, mtimecmp: '1, mtime: '0, ready: 1'b0, rdata: '0, mtip: 1'b0
  };

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wr;
  } clint_req_type;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] data,
                                              input logic [3:0] strb);
    logic [31:0] m;
    m = old;
    for (int i = 0; i < 4; i++) m[8*i+:8] = strb[i] ? data[8*i+:8] : old[8*i+:8];
    return m;
  endfunction
endpackage

// File: rtl/clint_timer_if.sv
// clint_timer_if: core data-bus request/response signals seen by the CLINT.
interface clint_timer_if;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  modport master(output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
                 input mem_rdata, mem_ready);
  modport slave(input mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
                output mem_rdata, mem_ready);
endinterface

// File: rtl/clint_tick.sv
// clint_tick: prescaler down-counter emitting a 1-cycle mtime tick; exists only with CLINT_PRESCALER_EN.
`ifdef CLINT_PRESCALER_EN
module clint_tick #(
  parameter int PRESCALE = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic reload,
  output logic tick
);
  logic [15:0] count;
  assign tick = count == '0;
  always_ff @(posedge clk)
    count <= rst ? '0 : (reload || tick) ? 16'(PRESCALE - 1) : count - 16'd1;
endmodule
`endif

// File: rtl/clint_timer.sv
// clint_timer: memory-mapped mtime/mtimecmp/msip with registered mtip.
// Optional prescaler enabled by defining CLINT_PRESCALER_EN.
module clint_timer
  import clint_timer_pkg::*;
#(
  parameter int PRESCALE = 100
) (
  input  logic          clk,
  input  logic          rst,
  clint_timer_if.slave  bus,
  output logic          mtip,
  output logic          msip,
  output logic [63:0]   mtime
);
  if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
    $error("PRESCALE out of range");
  end
  clint_reg_type r, rin;
  clint_req_type q, qin;
  logic        tick, accept, commit, wr_lo, wr_hi, unused_addr;
  logic [15:0] a;
  logic [31:0] rd;
  assign unused_addr = ^bus.mem_addr[31:16];
  assign a      = bus.mem_addr[15:0];
  assign accept = bus.mem_valid && !r.ready;
  assign commit = r.ready && q.wr;
  assign wr_lo  = commit && q.addr == clint_mtime;
  assign wr_hi  = commit && q.addr == clint_mtimeh;
`ifdef CLINT_PRESCALER_EN
  clint_tick #(.PRESCALE(PRESCALE)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .reload(wr_lo || wr_hi),
    .tick  (tick)
  );
`else
  assign tick = 1'b1;
`endif
  always_comb
    rd = a == clint_msip      ? {31'b0, r.msip} :
         a == clint_mtimecmp  ? r.mtimecmp[31:0] :
         a == clint_mtimecmph ? r.mtimecmp[63:32] :
         a == clint_mtime     ? r.mtime[31:0] :
         a == clint_mtimeh    ? r.mtime[63:32] : '0;
  // A write to either mtime word freezes the whole counter for that edge.
  always_comb begin
    rin = r;
    qin = q;
    rin.mtip  = r.mtime >= r.mtimecmp;
    rin.mtime = r.mtime + 64'(tick && !(wr_lo || wr_hi));
    if (wr_lo) rin.mtime[31:0] = merge_bytes(r.mtime[31:0], q.wdata, q.wstrb);
    if (wr_hi) rin.mtime[63:32] = merge_bytes(r.mtime[63:32], q.wdata, q.wstrb);
    if (commit && q.addr == clint_mtimecmp)
      rin.mtimecmp[31:0] = merge_bytes(r.mtimecmp[31:0], q.wdata, q.wstrb);
    if (commit && q.addr == clint_mtimecmph)
      rin.mtimecmp[63:32] = merge_bytes(r.mtimecmp[63:32], q.wdata, q.wstrb);
    if (commit && q.addr == clint_msip) rin.msip = q.wstrb[0] ? q.wdata[0] : r.msip;
    rin.ready = accept;
    rin.rdata = (accept && !bus.mem_instr && bus.mem_wstrb == '0) ? rd : '0;
    if (accept) begin
      qin.addr  = a;
      qin.wdata = bus.mem_wdata;
      qin.wstrb = bus.mem_wstrb;
      qin.wr    = !bus.mem_instr && bus.mem_wstrb != '0;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      r <= init_clint_reg;
      q <= '0;
    end else begin
      r <= rin;
      q <= qin;
    end
  assign bus.mem_ready = r.ready;
  assign bus.mem_rdata = r.rdata;
  assign mtip  = r.mtip;
  assign msip  = r.msip;
  assign mtime = r.mtime;
endmodule

// File: tb/tb_clint_timer.sv
// tb_clint_timer: random bus traffic against a transaction-level CLINT model, plus literal spot checks.
module tb_clint_timer;
`ifdef CLINT_PRESCALER_EN
  localparam int P = 4;
`else
  localparam int P = 1;
`endif
  logic clk = 0, rst = 1, mtip, msip;
  logic [63:0] mtime;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  clint_timer_if bus();
  clint_timer #(.PRESCALE(P)) dut (.clk(clk), .rst(rst), .bus(bus), .mtip(mtip), .msip(msip), .mtime(mtime));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // reference state: architectural registers plus the one outstanding request
  logic [63:0] m_mt, m_cmp;
  logic        m_sip, m_tip, m_rdy, p_wr;
  logic [31:0] m_rd, p_data;
  logic [15:0] p_addr;
  logic [3:0]  p_strb;
  int          m_left;

  function automatic logic [31:0] m_read(input logic [15:0] ad);
    case (ad)
      16'h0000: return {31'b0, m_sip};
      16'h4000: return m_cmp[31:0];
      16'h4004: return m_cmp[63:32];
      16'hBFF8: return m_mt[31:0];
      16'hBFFC: return m_mt[63:32];
      default:  return 32'h0;
    endcase
  endfunction

  task automatic model_step();
    logic [63:0] nmt, ncmp;
    logic nsip, ntip, nrdy, wmt;
    logic [31:0] nrd;
    int nleft;
    if (rst) begin
      m_mt = 0; m_cmp = '1; m_sip = 0; m_tip = 0; m_rdy = 0; m_rd = 0; m_left = 0; p_wr = 0;
      return;
    end
    ntip  = m_mt >= m_cmp;
    wmt   = m_rdy && p_wr && (p_addr == 16'hBFF8 || p_addr == 16'hBFFC);
    nmt   = m_mt + ((m_left == 0 && !wmt) ? 64'd1 : 64'd0);
    nleft = (wmt || m_left == 0) ? P - 1 : m_left - 1;
    ncmp  = m_cmp;
    nsip  = m_sip;
    if (m_rdy && p_wr)
      for (int i = 0; i < 4; i++)
        if (p_strb[i])
          case (p_addr)
            16'hBFF8: nmt[8*i+:8] = p_data[8*i+:8];
            16'hBFFC: nmt[32+8*i+:8] = p_data[8*i+:8];
            16'h4000: ncmp[8*i+:8] = p_data[8*i+:8];
            16'h4004: ncmp[32+8*i+:8] = p_data[8*i+:8];
            16'h0000: if (i == 0) nsip = p_data[0];
            default: ;
          endcase
    nrdy = bus.mem_valid && !m_rdy;
    nrd  = (nrdy && !bus.mem_instr && bus.mem_wstrb == 0) ? m_read(bus.mem_addr[15:0]) : 0;
    if (nrdy) begin
      p_addr = bus.mem_addr[15:0];
      p_data = bus.mem_wdata;
      p_strb = bus.mem_wstrb;
      p_wr   = !bus.mem_instr && bus.mem_wstrb != 0;
    end
    m_mt = nmt; m_cmp = ncmp; m_sip = nsip; m_tip = ntip; m_rdy = nrdy; m_rd = nrd; m_left = nleft;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("ready", bus.mem_ready, m_rdy);
      if (m_rdy) check("rdata", bus.mem_rdata, m_rd);
      check("mtime", mtime, m_mt);
      check("mtip", mtip, m_tip);
      check("msip", msip, m_sip);
    end
  end

  task automatic txn(input logic [15:0] ad, input logic [31:0] d, input logic [3:0] s,
                     input logic ins, output logic [31:0] rd);
    logic got = 0;
    @(negedge clk);
    bus.mem_valid = 1; bus.mem_addr = {16'($urandom), ad};
    bus.mem_wdata = d; bus.mem_wstrb = s; bus.mem_instr = ins;
    rd = 0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (bus.mem_ready) begin
        got = 1;
        rd = bus.mem_rdata;
      end
    end
    bus.mem_valid = 0;
    check("txn_ready", got, 1);
  endtask

  initial begin
    logic [31:0] rd, hs[3];
    logic [63:0] exp0[3], last;
    logic [15:0] addrs[7];
    int pulses, changes, hit;
    addrs = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC, 16'h1234, 16'h0004};
`ifdef CLINT_PRESCALER_EN
    exp0 = '{64'd0, 64'd1, 64'd1};
`else
    exp0 = '{64'd0, 64'd1, 64'd2};
`endif
    bus.mem_valid = 0; bus.mem_instr = 0; bus.mem_addr = 0; bus.mem_wdata = 0; bus.mem_wstrb = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      check("rst_mtime", mtime, exp0[k]);
      check("rst_mtip", mtip, 0);
      check("rst_msip", msip, 0);
      @(negedge clk);
    end
    txn(16'h4004, 0, 4'h0, 0, rd);
    check("cmph_reset", rd, 32'hFFFF_FFFF);
    txn(16'h4000, 32'h20, 4'hF, 0, rd);
    txn(16'h4004, 0, 4'hF, 0, rd);
    hit = 0;
    for (int k = 0; k < 400 && !hit; k++) begin
      @(negedge clk);
      if (mtime == 64'h20) hit = 1;
    end
    check("reach_20", hit, 1);
    check("mtip_pre", mtip, 0);
    @(negedge clk);
    check("mtip_set", mtip, 1);
    txn(16'h4000, 32'h1000, 4'hF, 0, rd);
    @(negedge clk);
    check("mtip_hold", mtip, 1);
    @(negedge clk);
    check("mtip_clear", mtip, 0);
    txn(16'h0000, 32'hFFFF_FFFF, 4'b0010, 0, rd);
    @(negedge clk);
    check("msip_strb1", msip, 0);
    txn(16'h0000, 32'hFFFF_FFFF, 4'b0001, 0, rd);
    @(negedge clk);
    check("msip_strb0", msip, 1);
    txn(16'h0000, 0, 4'h0, 0, rd);
    check("msip_read", rd, 32'h1);
    txn(16'hBFFC, 32'hFFFF_FFFF, 4'hF, 0, rd);
    txn(16'hBFF8, 32'hFFFF_FFFF, 4'hF, 0, rd);
    @(negedge clk);
    check("mtime_ones", mtime, '1);
`ifndef CLINT_PRESCALER_EN
    @(negedge clk);
    check("mtime_wrap", mtime, 0);
`endif
    repeat (10) @(negedge clk);
    txn(16'hBFF8, 32'h100, 4'hF, 0, rd);
    @(negedge clk);
    check("mtime_wr100", mtime, 64'h100);
    @(negedge clk);
    bus.mem_valid = 1; bus.mem_addr = 32'hBFF8; bus.mem_wstrb = 0; bus.mem_instr = 0;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.mem_ready) begin
        if (pulses < 3) hs[pulses] = bus.mem_rdata;
        pulses++;
      end
    end
    bus.mem_valid = 0;
    check("hs_pulses", pulses, 3);
`ifndef CLINT_PRESCALER_EN
    check("hs_step1", hs[1] - hs[0], 2);
    check("hs_step2", hs[2] - hs[1], 2);
`endif
    txn(16'h1234, 0, 4'h0, 0, rd);
    check("unmapped_rd", rd, 0);
    txn(16'hBFF8, 0, 4'h0, 1, rd);
    check("instr_rd", rd, 0);
    txn(16'h0000, 0, 4'hF, 1, rd);
    @(negedge clk);
    check("instr_wr", msip, 1);
`ifdef CLINT_PRESCALER_EN
    changes = 0;
    last = mtime;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (mtime != last) changes++;
      last = mtime;
    end
    check("presc_rate", changes, 2);
`endif
    repeat (300) begin
      logic [15:0] ad;
      logic [3:0] s;
      ad = addrs[$urandom_range(0, 6)];
      s = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
      if ((ad == 16'hBFFC || ad == 16'h4004) && s != 0 && $urandom_range(0, 3) != 0)
        txn(ad, 32'($urandom_range(0, 1)), s, 0, rd);
      else
        txn(ad, $urandom, s, $urandom_range(0, 7) == 0, rd);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if ($urandom_range(0, 40) == 0) begin
        @(negedge clk);
        rst = 1; bus.mem_valid = 1;
        @(negedge clk);
        rst = 0; bus.mem_valid = 0;
      end
    end
    @(negedge clk);
    bus.mem_valid = 1; bus.mem_addr = 32'hBFF8; bus.mem_wstrb = 0; rst = 1;
    @(negedge clk);
    rst = 0; bus.mem_valid = 0;
    check("rst_drop_ready", bus.mem_ready, 0);
    check("rst_drop_mtime", mtime, 0);
    @(negedge clk);
    check("rst_restart", mtime, 1);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
